adaptive_phase_sequencer: RTL and testbench

Phase sequencer for the adaptive intersection. It decides which of the four lanes (NS, SN, EW, WE) gets right-of-way, for how long, and when to pass through yellow and all-red. It produces the 4-bit `light_signal` phase code that the traffic light driver decodes into per-lane lamp outputs. Timing counts ticks of an external slow enable; lane choice is round-robin over lanes with vehicle demand, with an emergency override.

---
 rtl/traffic_pkg.sv | 37 +++
 rtl/phase_timer.sv | 28 ++
 rtl/adaptive_phase_sequencer.sv | 125 ++++++++++++
 tb/tb_adaptive_phase_sequencer.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/traffic_pkg.sv
// Shared definitions for the intersection: phase codes decoded by the light driver,
// lane indices, and the sequencer state encoding.
package traffic_pkg;

  localparam logic [3:0] ALL_RED   = 4'd0;
  localparam logic [3:0] NS_GREEN  = 4'd1;
  localparam logic [3:0] NS_YELLOW = 4'd2;
  localparam logic [3:0] SN_GREEN  = 4'd3;
  localparam logic [3:0] SN_YELLOW = 4'd4;
  localparam logic [3:0] EW_GREEN  = 4'd5;
  localparam logic [3:0] EW_YELLOW = 4'd6;
  localparam logic [3:0] WE_GREEN  = 4'd7;
  localparam logic [3:0] WE_YELLOW = 4'd8;

  localparam logic [1:0] LANE_NS = 2'd0;
  localparam logic [1:0] LANE_SN = 2'd1;
  localparam logic [1:0] LANE_EW = 2'd2;
  localparam logic [1:0] LANE_WE = 2'd3;

  typedef enum logic [1:0] {
    ST_ALL_RED = 2'd0,
    ST_GREEN   = 2'd1,
    ST_YELLOW  = 2'd2
  } seq_state_t;

  // Green is 2*lane+1, yellow is 2*lane+2; anything else shows all red.
  function automatic logic [3:0] phase_code(input seq_state_t st, input logic [1:0] lane);
    logic [3:0] base;
    base = {1'b0, lane, 1'b0};
    case (st)
      ST_GREEN:  phase_code = base + 4'd1;
      ST_YELLOW: phase_code = base + 4'd2;
      default:   phase_code = ALL_RED;
    endcase
  endfunction

endpackage

// File: rtl/phase_timer.sv
// Tick-enabled saturating elapsed counter; cleared on the tick that enters a new state.
module phase_timer #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_tick,
  input  logic             i_clear,
  output logic [CNT_W-1:0] o_count,
  output logic [CNT_W-1:0] o_count_inc
);

  localparam logic [CNT_W-1:0] L_MAX = '1;

  logic [CNT_W-1:0] r_count;

  assign o_count     = r_count;
  assign o_count_inc = (r_count == L_MAX) ? L_MAX : r_count + CNT_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_tick) begin
      r_count <= i_clear ? '0 : o_count_inc;
    end
  end

endmodule

// File: rtl/adaptive_phase_sequencer.sv
// Phase sequencer: round-robin green allocation over demanding lanes, gap-out / max-out,
// fixed yellow, all-red clearance, and a level-sensitive emergency override.
module adaptive_phase_sequencer
  import traffic_pkg::*;
#(
  parameter int GREEN_MIN   = 5,
  parameter int GREEN_MAX   = 20,
  parameter int YELLOW_TIME = 3,
  parameter int ALLRED_TIME = 1,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_tick,
  input  logic [3:0]       i_car_present,
  input  logic             i_emergency,
  input  logic [1:0]       i_emergency_lane,
  output logic [3:0]       o_light_signal,
  output logic             o_phase_start,
  output logic [1:0]       o_dbg_state,
  output logic [CNT_W-1:0] o_dbg_elapsed
);

  localparam logic [CNT_W-1:0] L_GMIN = CNT_W'(GREEN_MIN);
  localparam logic [CNT_W-1:0] L_GMAX = CNT_W'(GREEN_MAX);
  localparam logic [CNT_W-1:0] L_YEL  = CNT_W'(YELLOW_TIME);
  localparam logic [CNT_W-1:0] L_ARED = CNT_W'(ALLRED_TIME);

  seq_state_t       r_state, w_state_nxt;
  logic [1:0]       r_lane, w_lane_nxt;
  logic [1:0]       r_last_lane, w_last_lane_nxt;
  logic [3:0]       r_light, w_light_nxt;
  logic             r_phase_start, w_phase_start_nxt;
  logic [CNT_W-1:0] w_elapsed, w_e;
  logic             w_enter;
  logic             w_cand_valid;
  logic [1:0]       w_cand_lane;
  logic             w_em_hold;

  phase_timer #(.CNT_W(CNT_W)) u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_tick     (i_tick),
    .i_clear    (w_enter),
    .o_count    (w_elapsed),
    .o_count_inc(w_e)
  );

  // Round-robin scan: descending loop so the nearest lane after last_lane wins.
  always_comb begin
    w_cand_valid = 1'b0;
    w_cand_lane  = r_last_lane;
    if (i_emergency) begin
      w_cand_valid = 1'b1;
      w_cand_lane  = i_emergency_lane;
    end else begin
      for (int k = 4; k >= 1; k--) begin
        if (i_car_present[r_last_lane + 2'(k)]) begin
          w_cand_valid = 1'b1;
          w_cand_lane  = r_last_lane + 2'(k);
        end
      end
    end
  end

  assign w_em_hold = i_emergency && (i_emergency_lane == r_lane);

  always_comb begin
    w_state_nxt     = r_state;
    w_lane_nxt      = r_lane;
    w_last_lane_nxt = r_last_lane;
    if (i_tick) begin
      case (r_state)
        ST_ALL_RED: begin
          if ((w_e >= L_ARED) && w_cand_valid) begin
            w_state_nxt = ST_GREEN;
            w_lane_nxt  = w_cand_lane;
          end
        end
        ST_GREEN: begin
          if (!w_em_hold && (i_emergency || (w_e >= L_GMAX) ||
                             ((w_e >= L_GMIN) && !i_car_present[r_lane]))) begin
            w_state_nxt = ST_YELLOW;
          end
        end
        ST_YELLOW: begin
          if (w_e >= L_YEL) begin
            w_state_nxt     = ST_ALL_RED;
            w_last_lane_nxt = r_lane;
          end
        end
        default: w_state_nxt = ST_ALL_RED;
      endcase
    end
  end

  assign w_enter = (w_state_nxt != r_state);

  always_comb begin
    w_light_nxt       = phase_code(w_state_nxt, w_lane_nxt);
    w_phase_start_nxt = (r_state == ST_ALL_RED) && (w_state_nxt == ST_GREEN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_ALL_RED;
      r_lane        <= LANE_NS;
      r_last_lane   <= LANE_WE;
      r_light       <= ALL_RED;
      r_phase_start <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_lane        <= w_lane_nxt;
      r_last_lane   <= w_last_lane_nxt;
      r_light       <= w_light_nxt;
      r_phase_start <= w_phase_start_nxt;
    end
  end

  assign o_light_signal = r_light;
  assign o_phase_start  = r_phase_start;
  assign o_dbg_state    = r_state;
  assign o_dbg_elapsed  = w_elapsed;

endmodule

// File: tb/tb_adaptive_phase_sequencer.sv
// Directed bench for adaptive_phase_sequencer: gap-out, max-out rotation, skipping/idle
// saturation, emergency preemption, tick qualification and asynchronous reset.
module tb_adaptive_phase_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       i_tick;
  logic [3:0] i_car_present;
  logic       i_emergency;
  logic [1:0] i_emergency_lane;
  logic [3:0] o_light_signal;
  logic       o_phase_start;
  logic [1:0] o_dbg_state;
  logic [7:0] o_dbg_elapsed;

  int n_cmp = 0;
  int n_err = 0;
  logic [3:0] exp_q[$];

  adaptive_phase_sequencer dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .i_tick          (i_tick),
    .i_car_present   (i_car_present),
    .i_emergency     (i_emergency),
    .i_emergency_lane(i_emergency_lane),
    .o_light_signal  (o_light_signal),
    .o_phase_start   (o_phase_start),
    .o_dbg_state     (o_dbg_state),
    .o_dbg_elapsed   (o_dbg_elapsed)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic apply_reset();
    rst_n            = 1'b0;
    i_tick           = 1'b0;
    i_car_present    = 4'b0000;
    i_emergency      = 1'b0;
    i_emergency_lane = 2'd0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Three idle cycles, one tick cycle; returns at the negedge right after the tick edge.
  task automatic do_tick();
    repeat (3) @(negedge clk);
    i_tick = 1'b1;
    @(negedge clk);
    i_tick = 1'b0;
  endtask

  task automatic do_ticks(input int n);
    for (int i = 0; i < n; i++) do_tick();
  endtask

  task automatic expect_ticks(input string tag, input int n, input logic [3:0] code);
    for (int i = 0; i < n; i++) begin
      do_tick();
      check(tag, o_light_signal, code);
    end
  endtask

  initial begin
    // ---- basic gap-out ----
    apply_reset();
    check("reset_light", o_light_signal, 4'd0);
    check("reset_pstart", o_phase_start, 1'b0);
    check("reset_state", o_dbg_state, 2'd0);
    check("reset_elapsed", o_dbg_elapsed, 8'd0);
    i_car_present = 4'b0001;
    do_tick();
    check("gap_t1_light", o_light_signal, 4'd1);
    check("gap_t1_pstart", o_phase_start, 1'b1);
    do_tick();
    check("gap_t2_pstart", o_phase_start, 1'b0);
    check("gap_t2_light", o_light_signal, 4'd1);
    expect_ticks("gap_green_hold", 5, 4'd1);
    i_car_present = 4'b0000;
    do_tick();
    check("gap_t8_yellow", o_light_signal, 4'd2);
    expect_ticks("gap_yellow_hold", 2, 4'd2);
    do_tick();
    check("gap_t11_red", o_light_signal, 4'd0);

    // ---- max-out rotation over all four lanes ----
    apply_reset();
    i_car_present = 4'b1111;
    for (int l = 0; l < 4; l++) begin
      for (int i = 0; i < 20; i++) exp_q.push_back(4'(2 * l + 1));
      for (int i = 0; i < 3; i++) exp_q.push_back(4'(2 * l + 2));
      exp_q.push_back(4'd0);
    end
    exp_q.push_back(4'd1);
    while (exp_q.size() > 0) begin
      do_tick();
      check("maxout_seq", o_light_signal, exp_q.pop_front());
    end

    // ---- skipping and idle saturation ----
    apply_reset();
    i_car_present = 4'b0100;
    do_tick();
    check("skip_ew_green", o_light_signal, 4'd5);
    i_car_present = 4'b0000;
    expect_ticks("skip_green_min", 4, 4'd5);
    expect_ticks("skip_yellow", 3, 4'd6);
    do_tick();
    check("skip_red", o_light_signal, 4'd0);
    check("skip_red_elapsed0", o_dbg_elapsed, 8'd0);
    do_ticks(254);
    check("idle_elapsed_254", o_dbg_elapsed, 8'd254);
    do_tick();
    check("idle_elapsed_255", o_dbg_elapsed, 8'd255);
    do_ticks(3);
    check("idle_elapsed_sat", o_dbg_elapsed, 8'd255);
    check("idle_light", o_light_signal, 4'd0);

    // ---- emergency preemption ----
    apply_reset();
    i_car_present = 4'b0001;
    expect_ticks("emg_ns_green", 2, 4'd1);
    i_emergency      = 1'b1;
    i_emergency_lane = 2'd2;
    do_tick();
    check("emg_preempt_yellow", o_light_signal, 4'd2);
    expect_ticks("emg_yellow_full", 2, 4'd2);
    do_tick();
    check("emg_red", o_light_signal, 4'd0);
    do_tick();
    check("emg_ew_green", o_light_signal, 4'd5);
    check("emg_ew_pstart", o_phase_start, 1'b1);
    expect_ticks("emg_hold_past_max", 25, 4'd5);
    i_emergency = 1'b0;
    do_tick();
    check("emg_release_gapout", o_light_signal, 4'd6);

    // ---- tick qualification ----
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      i_car_present = 4'(1 << i);
      @(negedge clk);
      i_car_present = 4'b0000;
      do_tick();
      check("tickq_idle_light", o_light_signal, 4'd0);
    end
    i_car_present = 4'b0001;
    do_tick();
    check("tickq_green", o_light_signal, 4'd1);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      i_car_present = 4'b0000;
      @(negedge clk);
      @(negedge clk);
      i_car_present = 4'b0001;
      i_tick = 1'b1;
      @(negedge clk);
      i_tick = 1'b0;
      check("tickq_green_hold", o_light_signal, 4'd1);
    end

    // ---- reset mid-phase ----
    apply_reset();
    i_car_present = 4'b1111;
    do_ticks(45);
    check("rst_pre_sn_yellow", o_light_signal, 4'd4);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_async_light", o_light_signal, 4'd0);
    check("rst_async_state", o_dbg_state, 2'd0);
    @(negedge clk);
    rst_n = 1'b1;
    do_tick();
    check("rst_after_ns_first", o_light_signal, 4'd1);
    check("rst_after_pstart", o_phase_start, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
